// File: rtl/line_memory.sv
// line_memory: fixed-latency line store, one request in flight, saturating op counters
module line_memory #(
    parameter int BLOCK_SIZE = 16,
    parameter int MEM_DEPTH  = 16384,
    parameter int DELAY      = 50
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    is_input_valid,
    input  logic [31:0]             addr,
    input  logic                    mem_read,
    input  logic                    mem_write,
    input  logic [BLOCK_SIZE*8-1:0] din,
    output logic                    is_output_valid,
    output logic [BLOCK_SIZE*8-1:0] dout,
    output logic                    mem_ready,
    output logic [31:0]             num_reads,
    output logic [31:0]             num_writes
);
    localparam int W  = BLOCK_SIZE * 8;
    localparam int IW = $clog2(MEM_DEPTH);
    localparam int CW = $clog2(DELAY + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic          op_wr;
    logic [W-1:0]  wdata;
    logic [31:0]   rd_cnt, wr_cnt;
    logic          accept, finish;
    logic          unused_addr;
    logic [W-1:0]  mem [MEM_DEPTH] = '{default: '0};

    assign mem_ready       = state != BUSY;
    assign accept          = mem_ready && is_input_valid && (mem_read ^ mem_write);
    assign finish          = state == BUSY && cnt == '0;
    assign is_output_valid = state == DONE && !op_wr;
    assign num_reads       = rd_cnt;
    assign num_writes      = wr_cnt;
    assign unused_addr     = ^addr[31:IW];

    // state register; reset abandons any in-flight request
    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else        state <= state_nxt;

    // next state: DONE behaves like IDLE so a new request can start without a gap
    always_comb begin
        state_nxt = accept ? BUSY : finish ? DONE : state == BUSY ? BUSY : IDLE;
    end

    // request latch, latency countdown, read data and saturating counters
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            cnt    <= '0;
            idx    <= '0;
            op_wr  <= 1'b0;
            wdata  <= '0;
            dout   <= '0;
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else begin
            if (accept) begin
                cnt   <= CW'(DELAY - 1);
                idx   <= addr[IW-1:0];
                op_wr <= mem_write;
                wdata <= din;
            end else if (state == BUSY && !finish)
                cnt <= cnt - 1'b1;
            if (finish && !op_wr) begin
                dout   <= mem[idx];
                rd_cnt <= rd_cnt + 32'(rd_cnt != '1);
            end
            if (finish && op_wr)
                wr_cnt <= wr_cnt + 32'(wr_cnt != '1);
        end

    // array update at the end of a write; storage itself is never reset
    always_ff @(posedge clk)
        if (finish && op_wr) mem[idx] <= wdata;
endmodule
